// File: rtl/reg_write_sequencer.sv
// Write front-end for an enabled register bank: buffers (addr, data)
// requests in a small FIFO and retires one one-hot write per clock.
module reg_write_sequencer #(
  parameter int BITS   = 32,
  parameter int NUM    = 7,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [BITS-1:0]            in_data,
  input  logic                       hold,
  output logic [NUM-1:0]             wr_en,
  output logic [BITS-1:0]            wr_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err,
  output logic [ADDR_W-1:0]          err_addr,
  input  logic                       err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BITS-1:0]   data;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic [NUM-1:0]    r_wr_en;
  logic [BITS-1:0]   r_wr_data;
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  entry_t            w_head;
  logic              w_bad;
  logic [NUM-1:0]    w_onehot;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_push   = in_valid & ~w_full;
  assign w_pop    = (r_level != '0) & ~hold;
  assign w_head   = r_mem[r_rptr];
  assign w_bad    = ({1'b0, w_head.addr} >= (ADDR_W+1)'(NUM));
  assign w_onehot = NUM'(1) << w_head.addr;

  // Storage carries no reset; validity is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (w_push && reset_n) begin
      r_mem[r_wptr] <= '{addr: in_addr, data: in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_en   <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= '0;
      if (w_pop && !w_bad) begin
        r_wr_en   <= w_onehot;
        r_wr_data <= w_head.data;
      end
    end
  end

  // A bad retirement on the same edge as a clear takes priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_pop && w_bad) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) r_err_addr <= w_head.addr;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end
  end

  assign in_ready = ~w_full;
  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;
  assign level    = r_level;
  assign err      = r_err;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed self-checking bench for reg_write_sequencer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_reg_write_sequencer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_addr;
  logic [31:0] in_data;
  logic        hold;
  logic [6:0]  wr_en;
  logic [31:0] wr_data;
  logic [2:0]  level;
  logic        err;
  logic [2:0]  err_addr;
  logic        err_clr;

  int checks;
  int failures;

  reg_write_sequencer #(
    .BITS(32), .NUM(7), .ADDR_W(3), .DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .hold     (hold),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .level    (level),
    .err      (err),
    .err_addr (err_addr),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    hold     = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (wr_en !== 7'b0 || level !== 3'd0 || err !== 1'b0 ||
        in_ready !== 1'b1 || wr_data !== 32'h0 || err_addr !== 3'd0) begin
      failures++;
      $display("FAIL reset: wr_en=%b level=%0d err=%b rdy=%b data=%h ea=%0d, want 0 0 0 1 0 0",
               wr_en, level, err, in_ready, wr_data, err_addr);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_addr  = 3'd2;
    in_data  = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    checks++;
    if (wr_en !== 7'b0 || level !== 3'd1) begin
      failures++;
      $display("FAIL single_accept: wr_en=%b level=%0d, want 0000000 1", wr_en, level);
    end
    tick();
    checks++;
    if (wr_en !== 7'b0000100 || wr_data !== 32'hDEADBEEF || level !== 3'd0) begin
      failures++;
      $display("FAIL single_pulse: wr_en=%b data=%h level=%0d, want 0000100 deadbeef 0",
               wr_en, wr_data, level);
    end
    tick();
    checks++;
    if (wr_en !== 7'b0 || wr_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_end: wr_en=%b data=%h, want 0000000 deadbeef", wr_en, wr_data);
    end
  endtask

  task automatic test_hold_fill();
    logic [6:0] exp_en [5];
    exp_en[0] = 7'b0000001;
    exp_en[1] = 7'b0000010;
    exp_en[2] = 7'b0000100;
    exp_en[3] = 7'b0001000;
    exp_en[4] = 7'b0010000;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr  = 3'(i);
      in_data  = 32'hA000_0000 + 32'(i);
      tick();
    end
    checks++;
    if (level !== 3'd4 || in_ready !== 1'b0 || wr_en !== 7'b0) begin
      failures++;
      $display("FAIL hold_full: level=%0d rdy=%b wr_en=%b, want 4 0 0000000",
               level, in_ready, wr_en);
    end
    in_addr = 3'd4;
    in_data = 32'hA000_0004;
    tick();
    checks++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_stall: level=%0d rdy=%b, want 4 0", level, in_ready);
    end
    hold = 1'b0;
    tick();
    checks++;
    if (wr_en !== exp_en[0] || level !== 3'd3 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain0: wr_en=%b level=%0d rdy=%b, want %b 3 1",
               wr_en, level, in_ready, exp_en[0]);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (wr_en !== exp_en[1] || level !== 3'd3 || wr_data !== 32'hA000_0001) begin
      failures++;
      $display("FAIL drain1: wr_en=%b level=%0d data=%h, want %b 3 a0000001",
               wr_en, level, wr_data, exp_en[1]);
    end
    for (int k = 2; k < 5; k++) begin
      tick();
      checks++;
      if (wr_en !== exp_en[k] || wr_data !== 32'hA000_0000 + 32'(k) ||
          level !== 3'(4 - k)) begin
        failures++;
        $display("FAIL drain%0d: wr_en=%b data=%h level=%0d, want %b %h %0d",
                 k, wr_en, wr_data, level, exp_en[k], 32'hA000_0000 + 32'(k), 4 - k);
      end
    end
    tick();
    checks++;
    if (wr_en !== 7'b0 || level !== 3'd0) begin
      failures++;
      $display("FAIL drain_idle: wr_en=%b level=%0d, want 0 0", wr_en, level);
    end
  endtask

  task automatic test_bad_addr();
    in_valid = 1'b1;
    in_addr  = 3'd7;
    in_data  = 32'h7777_7777;
    tick();
    in_addr  = 3'd6;
    in_data  = 32'h6666_6666;
    tick();
    in_valid = 1'b0;
    checks++;
    if (wr_en !== 7'b0 || err !== 1'b1 || err_addr !== 3'd7 ||
        wr_data !== 32'hA000_0004) begin
      failures++;
      $display("FAIL bad7: wr_en=%b err=%b ea=%0d data=%h, want 0 1 7 a0000004",
               wr_en, err, err_addr, wr_data);
    end
    tick();
    checks++;
    if (wr_en !== 7'b1000000 || wr_data !== 32'h6666_6666 || err !== 1'b1) begin
      failures++;
      $display("FAIL good6: wr_en=%b data=%h err=%b, want 1000000 66666666 1",
               wr_en, wr_data, err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || err_addr !== 3'd0) begin
      failures++;
      $display("FAIL err_clr: err=%b ea=%0d, want 0 0", err, err_addr);
    end
    in_valid = 1'b1;
    in_addr  = 3'd7;
    in_data  = 32'h0;
    tick();
    in_valid = 1'b0;
    err_clr  = 1'b1;
    tick();
    err_clr  = 1'b0;
    checks++;
    if (err !== 1'b1 || err_addr !== 3'd7 || wr_en !== 7'b0) begin
      failures++;
      $display("FAIL clr_vs_set: err=%b ea=%0d wr_en=%b, want 1 7 0", err, err_addr, wr_en);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_flush();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_addr  = 3'(i);
      in_data  = 32'hF000_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd3) begin
      failures++;
      $display("FAIL flush_fill: level=%0d, want 3", level);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    hold    = 1'b0;
    checks++;
    if (level !== 3'd0 || wr_en !== 7'b0 || wr_data !== 32'h0) begin
      failures++;
      $display("FAIL flush: level=%0d wr_en=%b data=%h, want 0 0 0", level, wr_en, wr_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (wr_en !== 7'b0 || level !== 3'd0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL flush_quiet%0d: wr_en=%b level=%0d rdy=%b, want 0 0 1",
                 i, wr_en, level, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] last_data;
    last_data = 32'h0;
    hold = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        in_addr  = 3'(i);
        in_data  = 32'(i) * 32'h1111;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      checks++;
      if (level > 3'd1 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_level%0d: level=%0d rdy=%b, want <=1 1", i, level, in_ready);
      end
      if (i >= 1) begin
        logic [6:0] e_en;
        if (i - 1 < 7) begin
          e_en      = 7'(1 << (i - 1));
          last_data = 32'(i - 1) * 32'h1111;
        end else begin
          e_en = 7'b0;
        end
        checks++;
        if (wr_en !== e_en || wr_data !== last_data) begin
          failures++;
          $display("FAIL b2b_pulse%0d: wr_en=%b data=%h, want %b %h",
                   i - 1, wr_en, wr_data, e_en, last_data);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || err_addr !== 3'd7) begin
      failures++;
      $display("FAIL b2b_err: err=%b ea=%0d, want 1 7", err, err_addr);
    end
    tick();
    checks++;
    if (wr_en !== 7'b0 || level !== 3'd0) begin
      failures++;
      $display("FAIL b2b_idle: wr_en=%b level=%0d, want 0 0", wr_en, level);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_hold_fill();
    test_bad_addr();
    test_reset_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
